// File: rtl/issue_queue_alloc.sv
// rtl/issue_queue_alloc.sv - 16-entry issue queue with relative-age allocation and tag wakeup
module issue_queue_alloc #(
   parameter int OPCODE_WIDTH = 7,
   parameter int AGE_WIDTH    = 5,
   parameter int TAG_WIDTH    = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  logic [OPCODE_WIDTH-1:0] disp_op,
   input  logic [TAG_WIDTH-1:0]    disp_src1_tag,
   input  logic [TAG_WIDTH-1:0]    disp_src2_tag,
   input  logic                    disp_src1_rdy,
   input  logic                    disp_src2_rdy,
   input  logic [TAG_WIDTH-1:0]    disp_dst_tag,
   input  logic                    wake_valid,
   input  logic [TAG_WIDTH-1:0]    wake_tag,
   output logic [15:0]             req,
   output logic [OPCODE_WIDTH-1:0] op  [15:0],
   output logic [AGE_WIDTH-1:0]    age [15:0],
   input  logic                    grant,
   input  logic [3:0]              grant_addr,
   output logic                    iss_valid,
   output logic [OPCODE_WIDTH-1:0] iss_op,
   output logic [TAG_WIDTH-1:0]    iss_dst_tag,
   input  logic                    flush,
   output logic [4:0]              count
);

   logic [15:0]             r_valid;
   logic [OPCODE_WIDTH-1:0] r_op   [15:0];
   logic [TAG_WIDTH-1:0]    r_s1_tag [15:0];
   logic [TAG_WIDTH-1:0]    r_s2_tag [15:0];
   logic [15:0]             r_s1_rdy;
   logic [15:0]             r_s2_rdy;
   logic [TAG_WIDTH-1:0]    r_dst  [15:0];
   logic [AGE_WIDTH-1:0]    r_age  [15:0];
   logic [4:0]              r_count;
   logic                    r_iss_valid;
   logic [OPCODE_WIDTH-1:0] r_iss_op;
   logic [TAG_WIDTH-1:0]    r_iss_dst;

   logic                    w_disp_ok;
   logic                    w_grant_ok;
   logic [3:0]              w_free_idx;
   logic [AGE_WIDTH-1:0]    w_grant_age;
   logic [AGE_WIDTH-1:0]    w_new_age;
   logic                    w_s1_rdy_in;
   logic                    w_s2_rdy_in;

   assign req         = r_valid & r_s1_rdy & r_s2_rdy;
   assign disp_ready  = (r_count < 5'd16);
   assign count       = r_count;
   assign iss_valid   = r_iss_valid;
   assign iss_op      = r_iss_op;
   assign iss_dst_tag = r_iss_dst;

   assign w_disp_ok   = disp_valid & disp_ready;
   assign w_grant_ok  = grant & req[grant_addr];
   assign w_grant_age = r_age[grant_addr];
   // A same-cycle issue shrinks the queue, so the newcomer lands one age lower
   assign w_new_age   = AGE_WIDTH'(r_count - {4'b0, w_grant_ok});
   // Sources woken in the dispatch cycle would otherwise miss the broadcast forever
   assign w_s1_rdy_in = disp_src1_rdy | (wake_valid && (wake_tag == disp_src1_tag));
   assign w_s2_rdy_in = disp_src2_rdy | (wake_valid && (wake_tag == disp_src2_tag));

   // Expose stored fields; invalid slots report age 0
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         op[i]  = r_op[i];
         age[i] = r_valid[i] ? r_age[i] : '0;
      end
   end

   // Lowest-index empty slot, evaluated on cycle-start occupancy
   always_comb begin
      w_free_idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = 4'(i);
      end
   end

   // Entry state: grant removal with age compaction, wakeup, dispatch write, flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= '0;
         r_s1_rdy    <= '0;
         r_s2_rdy    <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
         r_iss_op    <= '0;
         r_iss_dst   <= '0;
         for (int i = 0; i < 16; i++) begin
            r_op[i]     <= '0;
            r_s1_tag[i] <= '0;
            r_s2_tag[i] <= '0;
            r_dst[i]    <= '0;
            r_age[i]    <= '0;
         end
      end else if (flush) begin
         r_valid     <= '0;
         r_count     <= '0;
         r_iss_valid <= 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (r_valid[i]) begin
               if (w_grant_ok && (grant_addr == 4'(i))) begin
                  r_valid[i] <= 1'b0;
               end else if (w_grant_ok && (r_age[i] > w_grant_age)) begin
                  r_age[i] <= r_age[i] - 1'b1;
               end
               if (wake_valid && (r_s1_tag[i] == wake_tag)) r_s1_rdy[i] <= 1'b1;
               if (wake_valid && (r_s2_tag[i] == wake_tag)) r_s2_rdy[i] <= 1'b1;
            end
         end
         if (w_disp_ok) begin
            r_valid[w_free_idx]  <= 1'b1;
            r_op[w_free_idx]     <= disp_op;
            r_s1_tag[w_free_idx] <= disp_src1_tag;
            r_s2_tag[w_free_idx] <= disp_src2_tag;
            r_s1_rdy[w_free_idx] <= w_s1_rdy_in;
            r_s2_rdy[w_free_idx] <= w_s2_rdy_in;
            r_dst[w_free_idx]    <= disp_dst_tag;
            r_age[w_free_idx]    <= w_new_age;
         end
         r_count     <= 5'(r_count + {4'b0, w_disp_ok} - {4'b0, w_grant_ok});
         r_iss_valid <= w_grant_ok;
         if (w_grant_ok) begin
            r_iss_op  <= r_op[grant_addr];
            r_iss_dst <= r_dst[grant_addr];
         end
      end
   end

endmodule

// File: tb/tb_issue_queue_alloc.sv
// tb/tb_issue_queue_alloc.sv - directed self-checking bench for issue_queue_alloc
module tb_issue_queue_alloc;

   logic        clk;
   logic        rst_n;
   logic        disp_valid;
   logic        disp_ready;
   logic [6:0]  disp_op;
   logic [5:0]  disp_src1_tag;
   logic [5:0]  disp_src2_tag;
   logic        disp_src1_rdy;
   logic        disp_src2_rdy;
   logic [5:0]  disp_dst_tag;
   logic        wake_valid;
   logic [5:0]  wake_tag;
   logic [15:0] req;
   logic [6:0]  op  [15:0];
   logic [4:0]  age [15:0];
   logic        grant;
   logic [3:0]  grant_addr;
   logic        iss_valid;
   logic [6:0]  iss_op;
   logic [5:0]  iss_dst_tag;
   logic        flush;
   logic [4:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   issue_queue_alloc #(.OPCODE_WIDTH(7), .AGE_WIDTH(5), .TAG_WIDTH(6)) dut (
      .clk(clk), .rst_n(rst_n),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
      .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
      .disp_dst_tag(disp_dst_tag), .wake_valid(wake_valid), .wake_tag(wake_tag),
      .req(req), .op(op), .age(age), .grant(grant), .grant_addr(grant_addr),
      .iss_valid(iss_valid), .iss_op(iss_op), .iss_dst_tag(iss_dst_tag),
      .flush(flush), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 1'b0; grant = 1'b0; wake_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic set_disp(input logic [6:0] o, input logic [5:0] t1, input logic r1,
                           input logic [5:0] t2, input logic r2, input logic [5:0] d);
      disp_valid = 1'b1; disp_op = o;
      disp_src1_tag = t1; disp_src1_rdy = r1;
      disp_src2_tag = t2; disp_src2_rdy = r2;
      disp_dst_tag = d;
   endtask

   initial begin
      rst_n = 1'b0; idle();
      disp_op = '0; disp_src1_tag = '0; disp_src2_tag = '0;
      disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0; disp_dst_tag = '0;
      wake_tag = '0; grant_addr = '0;
      step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_disp_ready", 32'(disp_ready), 32'd1);
      chk("rst_req", 32'(req), 32'h0);
      chk("rst_iss_valid", 32'(iss_valid), 32'd0);
      chk("rst_iss_op", 32'(iss_op), 32'd0);
      chk("rst_iss_dst", 32'(iss_dst_tag), 32'd0);
      rst_n = 1'b1;
      step();

      // A, B, C all ready -> slots 0..2, ages 0..2
      set_disp(7'd1, 6'd20, 1'b1, 6'd21, 1'b1, 6'd10); step();
      set_disp(7'd2, 6'd20, 1'b1, 6'd21, 1'b1, 6'd11); step();
      set_disp(7'd3, 6'd20, 1'b1, 6'd21, 1'b1, 6'd12); step();
      idle();
      chk("abc_req", 32'(req), 32'h0007);
      chk("abc_count", 32'(count), 32'd3);
      chk("abc_age0", 32'(age[0]), 32'd0);
      chk("abc_age1", 32'(age[1]), 32'd1);
      chk("abc_age2", 32'(age[2]), 32'd2);
      chk("abc_op1", 32'(op[1]), 32'd2);

      // Issue B
      grant = 1'b1; grant_addr = 4'd1; step(); idle();
      chk("gb_iss_valid", 32'(iss_valid), 32'd1);
      chk("gb_iss_op", 32'(iss_op), 32'd2);
      chk("gb_iss_dst", 32'(iss_dst_tag), 32'd11);
      chk("gb_age0", 32'(age[0]), 32'd0);
      chk("gb_age2", 32'(age[2]), 32'd1);
      chk("gb_count", 32'(count), 32'd2);
      chk("gb_req", 32'(req), 32'h0005);
      step();
      chk("gb_iss_drop", 32'(iss_valid), 32'd0);
      chk("gb_iss_hold", 32'(iss_op), 32'd2);

      // D waits on tag 5, reuses slot 1 with age 2
      set_disp(7'd4, 6'd5, 1'b0, 6'd21, 1'b1, 6'd13); step(); idle();
      chk("d_req", 32'(req), 32'h0005);
      chk("d_count", 32'(count), 32'd3);
      chk("d_age1", 32'(age[1]), 32'd2);
      wake_valid = 1'b1; wake_tag = 6'd5; step(); idle();
      chk("d_wake_req", 32'(req), 32'h0007);

      // Grant to empty slot 5 is ignored
      grant = 1'b1; grant_addr = 4'd5; step(); idle();
      chk("bad_grant_count", 32'(count), 32'd3);
      chk("bad_grant_iss", 32'(iss_valid), 32'd0);
      chk("bad_grant_req", 32'(req), 32'h0007);

      // E woken in its own dispatch cycle
      set_disp(7'd5, 6'd20, 1'b1, 6'd9, 1'b0, 6'd15);
      wake_valid = 1'b1; wake_tag = 6'd9; step(); idle();
      chk("e_req", 32'(req), 32'h000F);
      chk("e_age3", 32'(age[3]), 32'd3);

      // count=4: dispatch F and issue oldest (slot 0) together
      set_disp(7'd6, 6'd20, 1'b1, 6'd21, 1'b1, 6'd14);
      grant = 1'b1; grant_addr = 4'd0; step(); idle();
      chk("f_count", 32'(count), 32'd4);
      chk("f_req", 32'(req), 32'h001E);
      chk("f_age4", 32'(age[4]), 32'd3);
      chk("f_age1", 32'(age[1]), 32'd1);
      chk("f_age2", 32'(age[2]), 32'd0);
      chk("f_age3", 32'(age[3]), 32'd2);
      chk("f_iss_op", 32'(iss_op), 32'd1);

      // Fill slot 0 then 5..15
      for (int k = 0; k < 12; k++) begin
         set_disp(7'(8'h10 + k), 6'd20, 1'b1, 6'd21, 1'b1, 6'(k));
         step();
      end
      idle();
      chk("full_count", 32'(count), 32'd16);
      chk("full_ready", 32'(disp_ready), 32'd0);
      chk("full_req", 32'(req), 32'hFFFF);
      chk("full_age0", 32'(age[0]), 32'd4);
      chk("full_age15", 32'(age[15]), 32'd15);

      // Full: dispatch refused, grant of slot 0 (age 4) proceeds
      set_disp(7'h7F, 6'd20, 1'b1, 6'd21, 1'b1, 6'd63);
      grant = 1'b1; grant_addr = 4'd0; step(); idle();
      chk("fg_count", 32'(count), 32'd15);
      chk("fg_ready", 32'(disp_ready), 32'd1);
      chk("fg_req", 32'(req), 32'hFFFE);
      chk("fg_iss_op", 32'(iss_op), 32'h10);
      chk("fg_age15", 32'(age[15]), 32'd14);
      chk("fg_age1", 32'(age[1]), 32'd1);

      // Flush beats concurrent dispatch and grant
      set_disp(7'h22, 6'd20, 1'b1, 6'd21, 1'b1, 6'd1);
      grant = 1'b1; grant_addr = 4'd1; flush = 1'b1; step(); idle();
      chk("fl_count", 32'(count), 32'd0);
      chk("fl_req", 32'(req), 32'h0);
      chk("fl_iss", 32'(iss_valid), 32'd0);
      chk("fl_ready", 32'(disp_ready), 32'd1);

      // Asynchronous reset between edges
      set_disp(7'h33, 6'd20, 1'b1, 6'd21, 1'b1, 6'd2);
      grant = 1'b1; grant_addr = 4'd0; step(); idle();
      chk("ar_pre_count", 32'(count), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_count", 32'(count), 32'd0);
      chk("ar_req", 32'(req), 32'h0);
      chk("ar_iss_op", 32'(iss_op), 32'd0);
      step();
      rst_n = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
